// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the 5x5 switch allocator: port indices, per-output
// FSM encoding, the per-output context record and small index helpers.
package switch_allocator_pkg;

   localparam int NUM_PORTS = 5;

   // Port index encoding used for both input rows and output columns.
   localparam int PORT_E     = 0;
   localparam int PORT_W     = 1;
   localparam int PORT_N     = 2;
   localparam int PORT_S     = 3;
   localparam int PORT_EJECT = 4;

   typedef logic [2:0]           port_idx_t;
   typedef logic [NUM_PORTS-1:0] port_vec_t;

   // Per-output allocation state.
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } out_state_e;

   // Everything one output FSM remembers; also the debug view of that FSM.
   typedef struct packed {
      out_state_e state;
      port_idx_t  owner;
      port_idx_t  rr;
   } out_ctx_t;

   localparam out_ctx_t CTX_RESET = '{state: ST_IDLE, owner: 3'd0, rr: 3'd0};

   // Successor of a port index, wrapping 4 -> 0.
   function automatic port_idx_t next_port(input port_idx_t p);
      return (p == port_idx_t'(NUM_PORTS - 1)) ? port_idx_t'(0) : p + port_idx_t'(1);
   endfunction

   // Keep only the lowest set bit of a vector (two's complement trick).
   function automatic port_vec_t lowest_bit(input port_vec_t v);
      return v & (~v + port_vec_t'(1));
   endfunction

   // Index of the set bit in a one-hot vector; 0 when the vector is empty.
   function automatic port_idx_t onehot_to_idx(input port_vec_t v);
      port_idx_t r;
      r = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (v[i]) r = port_idx_t'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter: combinational 5-way round-robin pick. Requests are scanned
// starting at the pointer and moving upward modulo 5; the first requester
// found receives a one-hot grant. No requests gives an all-zero grant.
module rr_arbiter
   import switch_allocator_pkg::*;
(
   input  logic [4:0] req,
   input  logic [2:0] ptr,
   output logic [4:0] gnt
);

   port_idx_t idx;
   logic      found;

   // Walk the ring from the pointer and grant the first active request.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
         idx = next_port(idx);
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: 5x5 separable switch allocator for a mesh router.
// One independent IDLE/LOCKED FSM per output picks an owner input with a
// round-robin arbiter and holds it until release.
//
// Build option: define WORMHOLE_LOCK_EN for packet-level locking (an output
// is only released by a tail flit transfer or a dropped request). Without it
// every flit transfer releases the output, giving flit-level round-robin, and
// the tail input is ignored.
//
// Handshake: a flit moves on output o in any cycle where grant[i*5+o] and
// out_ready[o] are both high. The allocator never waits on anything else;
// a LOCKED output holds its grant indefinitely while out_ready is low.
module switch_allocator
   import switch_allocator_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [24:0] req,
   input  logic [4:0]  tail,
   input  logic [4:0]  out_ready,
   output logic [24:0] grant,
   output logic [4:0]  out_busy
);

   logic [24:0] req_red;
   port_vec_t   col_req      [NUM_PORTS];
   port_vec_t   arb_gnt      [NUM_PORTS];
   logic [4:0]  release_xfer;
   out_ctx_t    ctx_q        [NUM_PORTS];
   out_ctx_t    ctx_d        [NUM_PORTS];

   // Reduce each request row to its lowest requested output so an input
   // can never compete for (or hold) two outputs at once.
   always_comb begin
      req_red = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         req_red[i*NUM_PORTS +: NUM_PORTS] = lowest_bit(req[i*NUM_PORTS +: NUM_PORTS]);
      end
   end

   // Transpose the reduced request matrix into per-output request columns.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         col_req[o] = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            col_req[o][i] = req_red[i*NUM_PORTS + o];
         end
      end
   end

   // One round-robin arbiter per output, driven by that output's pointer.
   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
      rr_arbiter u_rr_arbiter (
         .req (col_req[o]),
         .ptr (ctx_q[o].rr),
         .gnt (arb_gnt[o])
      );
   end

`ifdef WORMHOLE_LOCK_EN
   // Packet-level locking: only a transfer of the owner's tail flit frees the output.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         release_xfer[o] = out_ready[o] & tail[ctx_q[o].owner];
      end
   end
`else
   // Flit-level round-robin: any transfer frees the output.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         release_xfer[o] = out_ready[o];
      end
   end

   logic unused_tail;
   assign unused_tail = ^tail;
`endif

   // State register: per-output context, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            ctx_q[o] <= CTX_RESET;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            ctx_q[o] <= ctx_d[o];
         end
      end
   end

   // Next-state logic: lock on an arbitration win, release on a qualifying
   // transfer or a dropped request. The release cycle never re-arbitrates,
   // so a freed output spends at least one cycle IDLE.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         ctx_d[o] = ctx_q[o];
         case (ctx_q[o].state)
            ST_IDLE: begin
               if ((|col_req[o]) && out_ready[o]) begin
                  ctx_d[o].state = ST_LOCKED;
                  ctx_d[o].owner = onehot_to_idx(arb_gnt[o]);
               end
            end
            ST_LOCKED: begin
               if (!col_req[o][ctx_q[o].owner] || release_xfer[o]) begin
                  ctx_d[o].state = ST_IDLE;
                  ctx_d[o].rr    = next_port(ctx_q[o].owner);
               end
            end
         endcase
      end
   end

   // Output decode: a LOCKED output drives its owner's grant bit and busy flag.
   always_comb begin
      grant    = '0;
      out_busy = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (ctx_q[o].state == ST_LOCKED) begin
            grant[int'(ctx_q[o].owner)*NUM_PORTS + o] = 1'b1;
            out_busy[o] = 1'b1;
         end
      end
   end

   // Structural invariants: every grant column and row is one-hot or zero,
   // and no owner or pointer ever leaves the 0..4 range.
   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_chk
      port_vec_t grant_col;

      // Gather column o of the grant matrix.
      always_comb begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            grant_col[i] = grant[i*NUM_PORTS + o];
         end
      end

      a_col_onehot0 : assert property (@(posedge clk) disable iff (reset)
         $onehot0(grant_col));
      a_row_onehot0 : assert property (@(posedge clk) disable iff (reset)
         $onehot0(grant[o*NUM_PORTS +: NUM_PORTS]));
      a_owner_range : assert property (@(posedge clk) disable iff (reset)
         (ctx_q[o].owner < port_idx_t'(NUM_PORTS)) && (ctx_q[o].rr < port_idx_t'(NUM_PORTS)));
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus randomized traffic,
// all checked by a scoreboard fed from a rule-level reference model.
module tb_switch_allocator;

   logic        clk;
   logic        reset;
   logic [24:0] req;
   logic [4:0]  tail;
   logic [4:0]  out_ready;
   logic [24:0] grant;
   logic [4:0]  out_busy;

   logic [29:0] exp_q[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic        mon_en    = 1'b0;

   // Reference model: owner per output (-1 = free) and round-robin start.
   int m_owner [5];
   int m_rr    [5];

   switch_allocator dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .tail      (tail),
      .out_ready (out_ready),
      .grant     (grant),
      .out_busy  (out_busy)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
      total_cnt++;
      if (act === req_val) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, req_val, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int o = 0; o < 5; o++) begin
         m_owner[o] = -1;
         m_rr[o]    = 0;
      end
   endfunction

   // Advance the model by one clock given the inputs sampled at that edge.
   function automatic void model_step(input logic [24:0] r, input logic [4:0] t, input logic [4:0] rdy);
      int want [5];
      int nxt_owner [5];
      int nxt_rr [5];
      bit rel;
      // Each input effectively asks for its lowest-numbered requested output.
      for (int i = 0; i < 5; i++) begin
         want[i] = -1;
         for (int o = 4; o >= 0; o--) begin
            if (r[i*5 + o]) want[i] = o;
         end
      end
      for (int o = 0; o < 5; o++) begin
         nxt_owner[o] = m_owner[o];
         nxt_rr[o]    = m_rr[o];
         if (m_owner[o] >= 0) begin
`ifdef WORMHOLE_LOCK_EN
            rel = (want[m_owner[o]] != o) || (rdy[o] && t[m_owner[o]]);
`else
            rel = (want[m_owner[o]] != o) || rdy[o];
`endif
            if (rel) begin
               nxt_owner[o] = -1;
               nxt_rr[o]    = (m_owner[o] + 1) % 5;
            end
         end else if (rdy[o]) begin
            for (int k = 0; k < 5; k++) begin
               if (nxt_owner[o] < 0 && want[(m_rr[o] + k) % 5] == o)
                  nxt_owner[o] = (m_rr[o] + k) % 5;
            end
         end
      end
      for (int o = 0; o < 5; o++) begin
         m_owner[o] = nxt_owner[o];
         m_rr[o]    = nxt_rr[o];
      end
   endfunction

   function automatic logic [29:0] model_exp();
      logic [24:0] g;
      logic [4:0]  b;
      g = '0;
      b = '0;
      for (int o = 0; o < 5; o++) begin
         if (m_owner[o] >= 0) begin
            g[m_owner[o]*5 + o] = 1'b1;
            b[o] = 1'b1;
         end
      end
      return {g, b};
   endfunction

   // Rule check independent of the model: rows and columns one-hot or zero.
   function automatic logic grant_shape_ok(input logic [24:0] g);
      logic [4:0] col;
      logic       ok;
      ok = 1'b1;
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) col[y] = g[y*5 + x];
         if (!$onehot0(col) || !$onehot0(g[x*5 +: 5])) ok = 1'b0;
      end
      return ok;
   endfunction

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic push_cycle();
      model_step(req, tail, out_ready);
      exp_q.push_back(model_exp());
   endtask

   task automatic drive(input logic [24:0] r, input logic [4:0] t, input logic [4:0] rdy);
      req       = r;
      tail      = t;
      out_ready = rdy;
      push_cycle();
      @(negedge clk);
   endtask

   // Let one more edge happen with the held inputs, then assert reset
   // asynchronously in the middle of the following cycle.
   task automatic mid_reset();
      push_cycle();
      @(posedge clk);
      #3;
      reset  = 1'b1;
      mon_en = 1'b0;
      #1;
      check("async_reset_grant", grant, 32'h0);
      check("async_reset_busy", out_busy, 32'h0);
      exp_q.delete();
      model_reset();
      req       = '0;
      tail      = '0;
      out_ready = '0;
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [29:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               check("exp_q_underflow", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("grant_busy", {2'b00, grant, out_busy}, {2'b00, e});
               check("grant_shape", {31'd0, grant_shape_ok(grant)}, 32'd1);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [4:0]  row [5];
      logic [24:0] r;
      logic [4:0]  rdy;

      reset     = 1'b1;
      req       = '0;
      tail      = '0;
      out_ready = '0;
      model_reset();
      #2;
      check("reset_grant", grant, 32'h0);
      check("reset_busy", out_busy, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Single request: input 0 -> N, granted one cycle later.
      drive(25'h0000004, 5'h00, 5'h1f);
      check("single_grant", grant, 32'h0000004);
      check("single_busy", out_busy, 32'h04);
      drive(25'h0, 5'h00, 5'h1f);
      drive(25'h0, 5'h00, 5'h1f);

      // Parallel allocation: input 0 -> W and input 2 -> Eject together.
      drive(25'h0004002, 5'h00, 5'h1f);
      check("parallel_grant", grant, 32'h0004002);
      check("parallel_busy", out_busy, 32'h12);
      drive(25'h0, 5'h00, 5'h1f);
      drive(25'h0, 5'h00, 5'h1f);

      // Contention on E from rr=0: inputs 1, 3, 4 rotate, then wrap to 1.
      drive(25'h0108020, 5'h1f, 5'h1f);
      check("contend_first", grant, 32'h0000020);
      for (int n = 0; n < 12; n++) drive(25'h0108020, 5'h1f, 5'h1f);
      drive(25'h0, 5'h00, 5'h1f);
      drive(25'h0, 5'h00, 5'h1f);

      // Backpressure: input 2 locks S, out_ready[S] low for 10 cycles.
      drive(25'h0002000, 5'h1f, 5'h1f);
      for (int n = 0; n < 10; n++) begin
         drive(25'h0002000, 5'h1f, 5'h17);
         check("bp_hold", grant, 32'h0002000);
      end
      drive(25'h0002000, 5'h1f, 5'h1f);
      check("bp_release", grant, 32'h0);
      drive(25'h0, 5'h00, 5'h1f);
      drive(25'h0, 5'h00, 5'h1f);

      // Alternation on S between inputs 0 and 1 with tail low.
      for (int n = 0; n < 10; n++) drive(25'h0000108, 5'h00, 5'h1f);
      drive(25'h0, 5'h00, 5'h1f);
      drive(25'h0, 5'h00, 5'h1f);

      // Mid-packet reset with E, W and N locked.
      drive(25'h0001041, 5'h00, 5'h1f);
      drive(25'h0001041, 5'h00, 5'h00);
      check("three_locked", out_busy, 32'h07);
      mid_reset();
      drive(25'h0108421, 5'h00, 5'h1f);
      check("post_reset_rr0", grant, 32'h0000001);
      drive(25'h0, 5'h00, 5'h1f);
      drive(25'h0, 5'h00, 5'h1f);

      // Randomized traffic with persistent, occasionally changing requests.
      for (int i = 0; i < 5; i++) row[i] = '0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 99) < 20) begin
               case ($urandom_range(0, 9))
                  0, 1:    row[i] = '0;
                  2:       row[i] = (5'd1 << $urandom_range(0, 4)) | (5'd1 << $urandom_range(0, 4));
                  default: row[i] = 5'd1 << $urandom_range(0, 4);
               endcase
            end
         end
         r = {row[4], row[3], row[2], row[1], row[0]};
         for (int o = 0; o < 5; o++) rdy[o] = ($urandom_range(0, 99) < 70);
         drive(r, 5'($urandom_range(0, 31)), rdy);
      end

      drive(25'h0, 5'h00, 5'h1f);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
